// File: rtl/circ_fifo.sv
// circ_fifo: single-clock circular-buffer FIFO with registered read data.
// DEPTH = 2**FIFO_DEPTH_W entries of DATA_W bits. The read and write pointers
// are FIFO_DEPTH_W+1 bits wide, and the extra MSB is a wrap bit.
// Optional feature macro: CIRC_FIFO_ERR_FLAGS_EN. When it is defined, the
// overflow/underflow pulses are registered. When it is undefined, both flags
// are tied to 0.
//
// Handshake semantics:
//   A write is accepted on a rising edge when wr_en_i=1 and full_o=0.
//   A read is accepted on a rising edge when rd_en_i=1 and empty_o=0. data_o
//   then shows the popped word from the following cycle and holds it until the
//   next accepted read.
//   A request that is not accepted leaves storage, pointers and data_o as they
//   were. With the error flags enabled, it is reported one cycle later as a
//   single-cycle overflow_o or underflow_o pulse.
module circ_fifo #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH_W = 2,
    parameter int ID           = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int DEPTH = 1 << FIFO_DEPTH_W;
    localparam logic [FIFO_DEPTH_W:0] PTR_ONE = 1;

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [FIFO_DEPTH_W:0]   r_wptr;
    logic [FIFO_DEPTH_W:0]   r_rptr;
    logic [DATA_W-1:0]       r_data;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic [FIFO_DEPTH_W-1:0] w_waddr;
    logic [FIFO_DEPTH_W-1:0] w_raddr;

    // ID is only an instance label. It drives nothing.
    logic [31:0]             w_unused_id;
    assign w_unused_id = 32'(ID);

    assign w_waddr  = r_wptr[FIFO_DEPTH_W-1:0];
    assign w_raddr  = r_rptr[FIFO_DEPTH_W-1:0];

    // Equal pointers mean empty. Equal low bits with different wrap bits
    // mean the writer is exactly one lap ahead, which means full.
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (w_waddr == w_raddr) &&
                      (r_wptr[FIFO_DEPTH_W] != r_rptr[FIFO_DEPTH_W]);

    // Acceptance looks only at the current flags. So a write while full is
    // dropped even if a read frees a slot on the same edge. Likewise, a read
    // while empty never sees the word being written on that edge.
    assign w_wr_acc = wr_en_i && !w_full;
    assign w_rd_acc = rd_en_i && !w_empty;

    // Storage write. The storage has no reset; the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            r_mem[w_waddr] <= data_i;
        end
    end

    // Pointer advance on accepted transfers. Each pointer wraps naturally at
    // 2**(FIFO_DEPTH_W+1).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Registered read data. It loads only on an accepted read and holds
    // otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '0;
        end else if (w_rd_acc) begin
            r_data <= r_mem[w_raddr];
        end
    end

`ifdef CIRC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Error pulses: each one is high for exactly the cycle after a rejected
    // request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en_i && w_full;
            r_underflow <= rd_en_i && w_empty;
        end
    end

    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

    assign data_o  = r_data;
    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule

// File: tb/tb_circ_fifo.sv
// tb_circ_fifo: directed bench for circ_fifo.
// The main instance uses the defaults (DATA_W=8, FIFO_DEPTH_W=2). The second
// instance (DATA_W=1) covers the single-bit data path. Expected read data comes
// from a queue that the stimulus fills and drains. The flag expectations follow
// the CIRC_FIFO_ERR_FLAGS_EN setting.
module tb_circ_fifo;

`ifdef CIRC_FIFO_ERR_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0: 8-bit x 4 ----------------
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;

    circ_fifo #(.DATA_W(8), .FIFO_DEPTH_W(2), .ID(0)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wr_en_i     (wr_en),
        .rd_en_i     (rd_en),
        .data_i      (din),
        .data_o      (dout),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (ovf),
        .underflow_o (unf)
    );

    // ---------------- DUT 1: 1-bit x 4 ----------------
    logic       wr_en1;
    logic       rd_en1;
    logic [0:0] din1;
    logic [0:0] dout1;
    logic       full1;
    logic       empty1;
    logic       ovf1;
    logic       unf1;

    circ_fifo #(.DATA_W(1), .FIFO_DEPTH_W(2), .ID(1)) u_dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wr_en_i     (wr_en1),
        .rd_en_i     (rd_en1),
        .data_i      (din1),
        .data_o      (dout1),
        .full_o      (full1),
        .empty_o     (empty1),
        .overflow_o  (ovf1),
        .underflow_o (unf1)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_data;
    int         n_vec;
    int         n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one rising edge, then settle 1ns past it before any sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of requests to DUT 0. The reference queue decides what
    // is accepted. All outputs are then checked against the expected state.
    task automatic xfer(input bit wr, input bit rd, input logic [7:0] d, input string tag);
        bit exp_ovf;
        bit exp_unf;
        exp_ovf = wr && (exp_q.size() == 4);
        exp_unf = rd && (exp_q.size() == 0);
        if (rd && exp_q.size() != 0) exp_data = exp_q.pop_front();
        if (wr && !exp_ovf)          exp_q.push_back(d);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check({tag, ".data"},  dout,  exp_data);
        check({tag, ".full"},  full,  exp_q.size() == 4);
        check({tag, ".empty"}, empty, exp_q.size() == 0);
        check({tag, ".ovf"},   ovf,   FLAGS_ON & exp_ovf);
        check({tag, ".unf"},   unf,   FLAGS_ON & exp_unf);
    endtask

    task automatic xfer1(input bit wr, input bit rd);
        wr_en1 = wr;
        rd_en1 = rd;
        tick();
        wr_en1 = 1'b0;
        rd_en1 = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] fill_tbl [4];
        fill_tbl[0] = 8'h11;
        fill_tbl[1] = 8'h22;
        fill_tbl[2] = 8'h33;
        fill_tbl[3] = 8'h44;
        n_vec    = 0;
        n_err    = 0;
        exp_data = 8'h00;
        wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        wr_en1 = 1'b0; rd_en1 = 1'b0; din1 = 1'b1;

        // Check the reset state while reset is held, then release between edges.
        rst_n = 1'b0;
        #3;
        check("rst.empty", empty, 1);
        check("rst.full",  full,  0);
        check("rst.data",  dout,  8'h00);
        check("rst.ovf",   ovf,   0);
        check("rst.unf",   unf,   0);
        check("rst.empty1", empty1, 1);
        tick();
        tick();
        rst_n = 1'b1;

        // Fill with 0x11..0x44. The FIFO is full after the fourth write.
        for (int i = 0; i < 4; i++) xfer(1'b1, 1'b0, fill_tbl[i], "fill");
        check("fill.full_hand", full, 1);

        // Write while full: the write is dropped and overflow pulses once.
        xfer(1'b1, 1'b0, 8'h55, "ovf_wr");
        xfer(1'b0, 1'b0, 8'h00, "ovf_idle");

        // Drain the FIFO. The data must come back in order, never as 0x55.
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 1'b1, 8'h00, "drain");
            check("drain.hand", dout, fill_tbl[i]);
        end
        check("drain.empty_hand", empty, 1);

        // Read while empty: data_o keeps 0x44 and underflow pulses once.
        xfer(1'b0, 1'b1, 8'h00, "unf_rd");
        check("unf_rd.hold", dout, 8'h44);
        xfer(1'b0, 1'b0, 8'h00, "unf_idle");

        // Read and write on the same edge while empty: only the write lands.
        xfer(1'b1, 1'b1, 8'hA0, "rw_empty");

        // Get to 2 entries, then run 10 simultaneous read+write cycles.
        // These cycles carry the pointers across a wrap.
        xfer(1'b1, 1'b0, 8'hA1, "pre2");
        for (int i = 0; i < 10; i++) xfer(1'b1, 1'b1, 8'hB0 + 8'(i), "rw10");
        check("rw10.count", exp_q.size(), 2);

        // Fill, then read and write on the same edge while full: only the
        // read is accepted.
        xfer(1'b1, 1'b0, 8'hC0, "fill3");
        xfer(1'b1, 1'b0, 8'hC1, "fill4");
        xfer(1'b1, 1'b1, 8'hC2, "rw_full");

        // 3 entries remain. Assert reset between edges; its effect must be
        // immediate.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.empty", empty, 1);
        check("midrst.full",  full,  0);
        check("midrst.data",  dout,  8'h00);
        check("midrst.ovf",   ovf,   0);
        exp_q.delete();
        exp_data = 8'h00;
        tick();
        rst_n = 1'b1;

        // The first read after reset returns the first write after reset.
        xfer(1'b1, 1'b0, 8'hD7, "post_wr");
        xfer(1'b0, 1'b1, 8'h00, "post_rd");
        check("post_rd.hand", dout, 8'hD7);

        // 1-bit instance: full after 4 writes, empty after 4 reads.
        for (int i = 0; i < 4; i++) begin
            xfer1(1'b1, 1'b0);
            check("w1.full",  full1,  i == 3);
            check("w1.empty", empty1, 0);
        end
        for (int i = 0; i < 4; i++) begin
            xfer1(1'b0, 1'b1);
            check("w1.data",  dout1,  1);
            check("w1.empty", empty1, i == 3);
            check("w1.full",  full1,  0);
        end
        xfer1(1'b1, 1'b0);
        xfer1(1'b1, 1'b0);
        xfer1(1'b1, 1'b0);
        xfer1(1'b1, 1'b0);
        xfer1(1'b1, 1'b0);
        check("w1.ovf", ovf1, FLAGS_ON);
        xfer1(1'b0, 1'b0);
        check("w1.ovf_clr", ovf1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/circ_fifo.md
CIRC_FIFO -- requirements
Module: circ_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH_W, default 2, log2 of depth; DEPTH = 2**FIFO_DEPTH_W entries (FIFO_DEPTH_W >= 1).
REQ-003 SHALL have parameter ID, default 0, instance identifier; no effect on any output.
REQ-004 SHALL have one clock and asynchronous active-low reset: clk_i and rst_ni.
REQ-005 clk_i  input  1  single clock; all state changes on rising edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 wr_en_i  input  1  write request.
REQ-008 rd_en_i  input  1  read request.
REQ-009 data_i  input  DATA_W  write data.
REQ-010 data_o  output  DATA_W  read data, registered.
REQ-011 full_o  output  1  high when DEPTH entries are stored.
REQ-012 empty_o  output  1  high when 0 entries are stored.
REQ-013 overflow_o  output  1  one-cycle pulse: write attempted while full.
REQ-014 underflow_o  output  1  one-cycle pulse: read attempted while empty.

Function
REQ-015 SHALL be a circular buffer of DEPTH x DATA_W storage, with write and read pointers of FIFO_DEPTH_W+1 bits; the MSB is the wrap bit.
REQ-016 Write accepted iff wr_en_i=1 and full_o=0: data_i stored at wptr[FIFO_DEPTH_W-1:0]; wptr increments modulo 2**(FIFO_DEPTH_W+1).
REQ-017 Read accepted iff rd_en_i=1 and empty_o=0: data_o loads mem[rptr[FIFO_DEPTH_W-1:0]] at that edge, visible the next cycle (1-cycle latency); rptr increments.
REQ-018 data_o SHALL hold its value when no read is accepted.
REQ-019 empty_o = (wptr == rptr); full_o = (low bits equal AND wrap bits differ); both combinational from registered pointers.
REQ-020 Simultaneous read and write, neither full nor empty: both accepted; occupancy unchanged.
REQ-021 Simultaneous read and write while full: only the read is accepted; the write is dropped and flagged as overflow.
REQ-022 Simultaneous read and write while empty: only the write is accepted; the read is flagged as underflow; no read-through of data_i.
REQ-023 A rejected write SHALL NOT modify storage or pointers; a rejected read SHALL NOT modify data_o or pointers.
REQ-024 overflow_o SHALL be registered: high for exactly the cycle after each rejected write; likewise underflow_o for rejected reads.
REQ-025 Pointer wrap SHALL be seamless: order preserved across any number of wraps.

Reset
REQ-026 rst_ni=0 SHALL immediately clear wptr, rptr, data_o, overflow_o, underflow_o to 0, regardless of clk_i.
REQ-027 During and after reset: empty_o=1, full_o=0; storage contents need not be cleared.
REQ-028 Reset mid-operation SHALL discard all stored entries; first post-reset read returns the first post-reset write.

Configuration
REQ-029 Macro CIRC_FIFO_ERR_FLAGS_EN defined: overflow_o/underflow_o logic per REQ-013, 014, 024.
REQ-030 Macro CIRC_FIFO_ERR_FLAGS_EN undefined: overflow_o and underflow_o SHALL be constant 0 with no flag registers; all other behaviour is identical.

Verification
REQ-031 FIFO_DEPTH_W=2, DATA_W=8: reset, write 0x11,0x22,0x33,0x44 -> full_o=1 after 4th write; reads return 0x11..0x44 in order, each one cycle after rd_en_i; empty_o=1 after the 4th read.
REQ-032 Full FIFO, write 0x55 alone -> write dropped; overflow_o=1 for one cycle (macro on); subsequent reads never return 0x55.
REQ-033 Empty FIFO, rd_en_i=1 -> data_o unchanged; underflow_o=1 for one cycle (macro on); 0 with the macro off.
REQ-034 2 entries stored, rd_en_i=wr_en_i=1 for 10 cycles -> empty_o=0 and full_o=0 throughout; data order preserved across pointer wrap.
REQ-035 Assert rst_ni=0 with 3 entries stored, between clock edges -> empty_o=1 immediately; data_o=0.
REQ-036 DATA_W=1, FIFO_DEPTH_W=2, constant data_i=1 -> full_o after 4 writes; empty_o after 4 reads; flags follow REQ-019.
